bit_pos_decoder: RTL and testbench
==================================

BIT_POS_DECODER -- requirements
Module: bit_pos_decoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port start, input, 1 bit: request to decode pos; accepted only in IDLE.
REQ-004 SHALL have port pos, input, 8 bits: bit position of a 233-bit field element; valid 0..233.
REQ-005 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-006 SHALL have port done, output, 1 bit: one-cycle pulse marking valid results.
REQ-007 SHALL have port word_idx, output, 4 bits: 18-bit word index, floor(pos/18).
REQ-008 SHALL have port bit_off, output, 5 bits: bit offset within the word, pos mod 18.
REQ-009 SHALL have port err, output, 1 bit: high when the accepted pos is greater than 233.
REQ-010 SHALL have parameter WORD_W, default 18: word width in bits.
REQ-011 SHALL have parameter MAX_POS, default 233: largest legal position.

Function
REQ-012 SHALL decode position to (word, offset), the inverse of the word-base mapping index*18, where base(i) = 18*i for i = 0..12.
REQ-013 SHALL implement the states IDLE, SUB and DONE, with all outputs registered.
REQ-014 SHALL, when start=1 in IDLE at edge E0 and pos<=MAX_POS, latch rem=pos and idx=0 and go to SUB.
REQ-015 SHALL, when start=1 in IDLE at edge E0 and pos>MAX_POS, go directly to DONE with err=1, word_idx=0 and bit_off=0.
REQ-016 SHALL, at each edge in SUB with rem>=WORD_W, set rem=rem-WORD_W and idx=idx+1, staying in SUB.
REQ-017 SHALL, at the edge in SUB with rem<WORD_W, load word_idx=idx, bit_off=rem and err=0, then go to DONE.
REQ-018 SHALL have done high exactly while in DONE, for one cycle; DONE SHALL return to IDLE on the next edge.
REQ-019 SHALL, for legal pos, assert done in the cycle after edge E(q+1), where q=floor(pos/18); the worst case is pos 216..233 at 13 edges.
REQ-020 SHALL, for illegal pos, assert done in the cycle after E0.
REQ-021 SHALL ignore start while busy=1, including the DONE cycle, with no effect on the in-flight operation.
REQ-022 SHALL ignore changes on pos after the edge that accepts start.
REQ-023 SHALL hold word_idx, bit_off and err stable from the DONE cycle until the next accepted start produces new results; they are not cleared in IDLE.
REQ-024 SHALL size internal rem as 8 bits and idx as 4 bits; idx SHALL never exceed 12 for legal input.
REQ-025 SHALL, when start is held high continuously, accept a new request at the first IDLE cycle after DONE.

Reset
REQ-026 SHALL, on rstn=0 at any time including mid-SUB, immediately force state to IDLE and set busy=0, done=0, word_idx=0, bit_off=0 and err=0.
REQ-027 SHALL, after reset, discard any aborted operation and produce no done pulse for it.
REQ-028 SHALL accept start at the first rising edge of clk after rstn deasserts.

Verification
REQ-029 Bench SHALL cover pos=0, start pulse -> done after 1 edge, word_idx=0, bit_off=0, err=0.
REQ-030 Bench SHALL cover pos=233 -> done after 13 edges, word_idx=12, bit_off=17, err=0, busy high for 13 cycles.
REQ-031 Bench SHALL cover pos=162 and pos=17 -> (9,0) after 10 edges and (0,17) after 1 edge.
REQ-032 Bench SHALL cover pos=234 and pos=255 -> done in the cycle after E0, err=1, word_idx=0, bit_off=0.
REQ-033 Bench SHALL cover start with pos=100 during busy of pos=200 -> only the result (11,2) appears, followed by a single done pulse.
REQ-034 Bench SHALL cover rstn low for 1 cycle during SUB of pos=233 -> all outputs 0, no done; a following start with pos=40 yields (2,4).

Source files
------------

// File: rtl/bit_pos_decoder.sv
// bit_pos_decoder: converts a bit position within a multi-word field element
// into (word index, bit offset) by repeated subtraction of the word width.
// One subtraction per clock keeps the datapath to a single narrow subtractor;
// latency is floor(pos/WORD_W)+1 edges after acceptance.
// All outputs come straight from flops.
module bit_pos_decoder #(
    parameter int unsigned WORD_W  = 18,
    parameter int unsigned MAX_POS = 233
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [7:0] pos,
    output logic       busy,
    output logic       done,
    output logic [3:0] word_idx,
    output logic [4:0] bit_off,
    output logic       err
);

    // Parameters narrowed once so every compare/subtract is 8 bits wide.
    localparam logic [7:0] WordW8  = 8'(WORD_W);
    localparam logic [7:0] MaxPos8 = 8'(MAX_POS);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSub  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] rem_q, rem_d;
    logic [3:0] idx_q, idx_d;
    logic [3:0] word_idx_d;
    logic [4:0] bit_off_d;
    logic       err_d;
    logic       busy_d;
    logic       done_d;

    // Next-state, datapath and registered-output next values.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        idx_d      = idx_q;
        word_idx_d = word_idx;
        bit_off_d  = bit_off;
        err_d      = err;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (pos > MaxPos8) begin
                        // Out-of-range position: report immediately, no iteration.
                        err_d      = 1'b1;
                        word_idx_d = 4'd0;
                        bit_off_d  = 5'd0;
                        state_d    = StDone;
                    end else begin
                        rem_d   = pos;
                        idx_d   = 4'd0;
                        state_d = StSub;
                    end
                end
            end
            StSub: begin
                if (rem_q >= WordW8) begin
                    rem_d = rem_q - WordW8;
                    idx_d = idx_q + 4'd1;
                end else begin
                    // rem < WORD_W here, so the low 5 bits hold it exactly.
                    word_idx_d = idx_q;
                    bit_off_d  = rem_q[4:0];
                    err_d      = 1'b0;
                    state_d    = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Status flags follow the next state so they are flop outputs aligned with it.
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    // State, working registers and outputs; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            rem_q    <= 8'd0;
            idx_q    <= 4'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            word_idx <= 4'd0;
            bit_off  <= 5'd0;
            err      <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            idx_q    <= idx_d;
            busy     <= busy_d;
            done     <= done_d;
            word_idx <= word_idx_d;
            bit_off  <= bit_off_d;
            err      <= err_d;
        end
    end

endmodule

// File: tb/tb_bit_pos_decoder.sv
// Directed bench for bit_pos_decoder: inputs change and outputs are sampled
// on the falling clock edge, away from the active rising edge.
module tb_bit_pos_decoder;

    logic       clk;
    logic       rstn;
    logic       start;
    logic [7:0] pos;
    logic       busy;
    logic       done;
    logic [3:0] word_idx;
    logic [4:0] bit_off;
    logic       err;

    int n_vec;
    int n_err;

    bit_pos_decoder #(
        .WORD_W (18),
        .MAX_POS(233)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .pos     (pos),
        .busy    (busy),
        .done    (done),
        .word_idx(word_idx),
        .bit_off (bit_off),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one request and check latency, busy duration and results.
    task automatic run(input string tag, input logic [7:0] p, input int exp_idx,
                       input int exp_off, input int exp_err, input int exp_edges);
        int edges;
        int busy_cnt;
        start = 1'b1;
        pos   = p;
        tick();                       // E0 accepts
        start = 1'b0;
        pos   = 8'hAA;                // must be ignored after acceptance
        edges    = 0;
        busy_cnt = 0;
        while (!done && edges < 20) begin
            if (busy) busy_cnt++;
            tick();
            edges++;
        end
        chk({tag, ".edges"}, edges, exp_edges);
        chk({tag, ".busy_cycles"}, busy_cnt, exp_edges);
        chk({tag, ".busy_in_done"}, busy, 1);
        chk({tag, ".word_idx"}, word_idx, exp_idx);
        chk({tag, ".bit_off"}, bit_off, exp_off);
        chk({tag, ".err"}, err, exp_err);
        tick();
        chk({tag, ".done_pulse"}, done, 0);
        chk({tag, ".busy_idle"}, busy, 0);
        tick();
        chk({tag, ".hold_idx"}, word_idx, exp_idx);
        chk({tag, ".hold_off"}, bit_off, exp_off);
        chk({tag, ".hold_err"}, err, exp_err);
    endtask

    initial begin
        int dones;
        n_vec = 0;
        n_err = 0;
        rstn  = 1'b0;
        start = 1'b0;
        pos   = 8'd0;

        // Reset state
        tick();
        tick();
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.word_idx", word_idx, 0);
        chk("rst.bit_off", bit_off, 0);
        chk("rst.err", err, 0);
        rstn = 1'b1;

        // Legal positions, including both range ends and word boundaries
        run("p0", 8'd0, 0, 0, 0, 1);
        run("p233", 8'd233, 12, 17, 0, 13);
        run("p162", 8'd162, 9, 0, 0, 10);
        run("p17", 8'd17, 0, 17, 0, 1);
        run("p18", 8'd18, 1, 0, 0, 2);

        // Illegal positions
        run("p234", 8'd234, 0, 0, 1, 0);
        run("p255", 8'd255, 0, 0, 1, 0);

        // Start during busy is ignored, including in the DONE cycle
        start = 1'b1;
        pos   = 8'd200;
        tick();
        pos   = 8'd100;               // start still high while busy
        tick();
        tick();
        tick();
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 20 && !done; i++) tick();
        chk("ovl.done", done, 1);
        chk("ovl.word_idx", word_idx, 11);
        chk("ovl.bit_off", bit_off, 2);
        chk("ovl.err", err, 0);
        start = 1'b1;                 // pulse during DONE only
        tick();
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (done) dones++;
            tick();
        end
        chk("ovl.extra_done", dones, 0);
        chk("ovl.busy", busy, 0);
        chk("ovl.hold_idx", word_idx, 11);
        chk("ovl.hold_off", bit_off, 2);

        // Asynchronous reset mid-SUB aborts with no done pulse
        start = 1'b1;
        pos   = 8'd233;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("abort.busy_before", busy, 1);
        rstn = 1'b0;
        #1;
        chk("abort.busy", busy, 0);
        chk("abort.done", done, 0);
        chk("abort.word_idx", word_idx, 0);
        chk("abort.bit_off", bit_off, 0);
        chk("abort.err", err, 0);
        @(negedge clk);
        rstn  = 1'b1;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            if (done || busy) dones++;
            tick();
        end
        chk("abort.no_done", dones, 0);
        run("p40", 8'd40, 2, 4, 0, 3);

        // Start held high: back-to-back requests, second accepted after DONE
        start = 1'b1;
        pos   = 8'd40;
        tick();                       // accepts 40
        for (int i = 0; i < 20 && !done; i++) tick();
        chk("hold.first_idx", word_idx, 2);
        pos = 8'd19;
        tick();                       // DONE -> IDLE
        chk("hold.idle_busy", busy, 0);
        tick();                       // IDLE accepts 19
        start = 1'b0;
        chk("hold.reaccept", busy, 1);
        for (int i = 0; i < 20 && !done; i++) tick();
        chk("hold.second_idx", word_idx, 1);
        chk("hold.second_off", bit_off, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
